alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
- Registered ALU-control decoder. Produces the 4-bit Operation code consumed by the combinational ALU from the main-control ALUOp field and the instruction funct3/funct7 fields.
- Adds a valid/ready handshake and a 2-entry output buffer, so the decode stage can sit between pipeline registers and absorb back-pressure without losing decodes.
- Flags encodings the ALU does not implement.

Parameters:
- OPCODE_LENGTH, 4, width of the emitted Operation code; must match the ALU.
- DEPTH, 2, output buffer entries; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept a request this cycle.
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- Funct3  in  3  instruction funct3.
- Funct7  in  7  instruction funct7 (imm[11:5] for I-type).
- out_valid  out  1  decoded entry available.
- out_ready  in  1  consumer accepts the head entry.
- Operation  out  OPCODE_LENGTH  ALU operation code of the head entry.
- illegal  out  1  head entry was an unsupported encoding.

Behaviour:
- Operation codes: AND 0000, OR 0001, XOR 0010, ADD 0011, BNE 0100, BLT 0101, BGE 0110, SLT 0111, BEQ 1000, SUB 1001, SRA 1010, SRL 1011, SLL 1100. Illegal entries carry 1111 (the ALU outputs 0 for it).
- ALUOp 00: ADD, regardless of funct fields.
- ALUOp 01, selected by Funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE; 010, 011, 110, 111 illegal.
- ALUOp 10, selected by Funct3:
  - 000: ADD if Funct7[5]=0, SUB if Funct7[5]=1.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL.
  - 101: SRL if Funct7[5]=0, SRA if Funct7[5]=1.
  - 011: illegal.
- ALUOp 11, selected by Funct3:
  - 000 ADD (Funct7 ignored), 010 SLT, 111 AND, 110 OR, 100 XOR, 001 SLL.
  - 101: SRL/SRA by Funct7[5].
  - 011: illegal.
- Transfers:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
- Latency: a pushed request appears on Operation/illegal with out_valid=1 one cycle after the push edge when the buffer was empty.
- Buffer ordering and visibility:
  - Strict FIFO order.
  - Operation/illegal reflect the head entry whenever out_valid=1.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- in_ready is a registered signal: 1 when occupancy < DEPTH.
  - A push while full is impossible; the requester must hold in_valid.
  - Combinational paths from out_ready to in_ready are not permitted.
- Boundary conditions:
  - Simultaneous push and pop at occupancy 1: occupancy stays 1 and the new entry becomes head next cycle.
  - Simultaneous push and pop at occupancy 0 cannot occur, since out_valid=0.
  - Pop at occupancy 0 is ignored.
  - in_valid=0 leaves the fields don't-care; nothing is decoded or stored.
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - Occupancy 0, out_valid=0, Operation=0000, illegal=0, in_ready=0 while asserted.
  - in_ready=1 from the first rising clk edge after deassertion.
  - Buffered entries are discarded.

Optional Feature:
- Macro: ALU_STRICT_DECODE_EN.
- Defined, R-type (ALUOp 10):
  - Funct7 must be 0000000, or 0100000 only for funct3 000/101; any other value is illegal.
- Defined, I-type (ALUOp 11):
  - funct3 001 requires Funct7=0000000.
  - funct3 101 requires Funct7 of 0000000 or 0100000; otherwise illegal.
- Not defined: only Funct7[5] is examined as listed above; other Funct7 bits are ignored and never cause illegal.
- Handshake, latency and codes are identical in both builds.

Test Plan:
- Reset: rst_n low mid-stream with 2 entries buffered -> out_valid=0, Operation=0000, illegal=0, in_ready=0; in_ready=1 one edge after release; no stale entry emerges.
- Full R-type sweep with out_ready=1:
  - ALUOp=10, Funct3=000/Funct7=0100000 -> 1001 one cycle later.
  - Funct3=101/Funct7=0100000 -> 1010.
  - Funct3=001 -> 1100.
  - Funct3=011 -> 1111 with illegal=1.
- Branch sweep: ALUOp=01 with Funct3=000, 001, 100, 101 -> 1000, 0100, 0101, 0110; Funct3=110 -> illegal=1.
- Back-pressure:
  - out_ready=0; push ADD then XOR -> in_ready drops to 0 after the second push.
  - Third request is held; Operation stays 0011.
  - Raise out_ready -> 0011, 0010, then the third entry, in order with no loss.
- Simultaneous push/pop at occupancy 1, every cycle for 20 cycles -> one result per cycle, in_ready constantly 1, order preserved.
- Strict decode: ALUOp=10, Funct3=111, Funct7=0000001 -> illegal=1 with the macro defined; 0000 (AND) with illegal=0 without it.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control decoder with a valid/ready handshake and a small output FIFO.
// Optional macro ALU_STRICT_DECODE_EN flags non-canonical Funct7 values as illegal.
module alu_ctrl_stage #(
    parameter int OPCODE_LENGTH = 4,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_XOR = 4'b0010,
        OP_ADD = 4'b0011,
        OP_BNE = 4'b0100,
        OP_BLT = 4'b0101,
        OP_BGE = 4'b0110,
        OP_SLT = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_SUB = 4'b1001,
        OP_SRA = 4'b1010,
        OP_SRL = 4'b1011,
        OP_SLL = 4'b1100,
        OP_ILL = 4'b1111
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    ill;
    } entry_t;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    alu_op_e dec_op;
    logic    dec_ill;
    entry_t  dec_entry;

`ifdef ALU_STRICT_DECODE_EN
    logic f7_zero;
    logic f7_alt;
    assign f7_zero = (Funct7 == 7'b0000000);
    assign f7_alt  = (Funct7 == 7'b0100000);
`else
    logic unused_f7;
    assign unused_f7 = ^{Funct7[6], Funct7[4:0]};
`endif

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        unique case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                unique case (Funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    default: dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                unique case (Funct3)
                    3'b000:  dec_op = Funct7[5] ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b100:  dec_op = OP_XOR;
                    3'b010:  dec_op = OP_SLT;
                    3'b001:  dec_op = OP_SLL;
                    3'b101:  dec_op = Funct7[5] ? OP_SRA : OP_SRL;
                    default: dec_ill = 1'b1;
                endcase
`ifdef ALU_STRICT_DECODE_EN
                // 0100000 is only meaningful as the SUB/SRA selector
                if (!(f7_zero || (f7_alt && (Funct3 == 3'b000 || Funct3 == 3'b101))))
                    dec_ill = 1'b1;
`endif
            end
            default: begin
                unique case (Funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b010:  dec_op = OP_SLT;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b100:  dec_op = OP_XOR;
                    3'b001:  dec_op = OP_SLL;
                    3'b101:  dec_op = Funct7[5] ? OP_SRA : OP_SRL;
                    default: dec_ill = 1'b1;
                endcase
`ifdef ALU_STRICT_DECODE_EN
                if (Funct3 == 3'b001 && !f7_zero)
                    dec_ill = 1'b1;
                if (Funct3 == 3'b101 && !(f7_zero || f7_alt))
                    dec_ill = 1'b1;
`endif
            end
        endcase
        if (dec_ill)
            dec_op = OP_ILL;
    end

    assign dec_entry = '{op: dec_op, ill: dec_ill};

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            ready_q;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push      = in_valid & ready_q;
    assign pop       = (count != '0) & out_ready;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '{default: '0};
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count   <= count_nxt;
            ready_q <= (count_nxt < CW'(DEPTH));
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (count != '0);
    assign Operation = out_valid ? OPCODE_LENGTH'(mem[rd_ptr].op) : '0;
    assign illegal   = out_valid & mem[rd_ptr].ill;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: directed decode sweeps, back-pressure, streaming and reset.
// Strict-decode expectations follow ALU_STRICT_DECODE_EN.
module tb_alu_ctrl_stage;

    typedef struct {
        logic [1:0] a;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] op;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Operation;
    logic       illegal;

    logic [4:0] q[$];
    logic [4:0] pend;
    logic       pushed;
    vec_t       tbl[$];
    int         checks = 0;
    int         errs   = 0;

    alu_ctrl_stage #(.OPCODE_LENGTH(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; evaluates the coming rising edge and returns at the next falling edge.
    task automatic tick();
        logic [4:0] head;
        #1;
        if (q.size() == 0) begin
            chk("spurious_out", {31'b0, out_valid & out_ready}, 32'd0);
        end else if (out_valid && out_ready) begin
            head = q.pop_front();
            chk("operation", {28'b0, Operation}, {28'b0, head[4:1]});
            chk("illegal", {31'b0, illegal}, {31'b0, head[0]});
        end
        pushed = in_valid && in_ready;
        if (pushed) q.push_back(pend);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input vec_t v);
        ALUOp    = v.a;
        Funct3   = v.f3;
        Funct7   = v.f7;
        pend     = {v.op, v.ill};
        in_valid = 1'b1;
    endtask

    task automatic send(input vec_t v);
        set_req(v);
        pushed = 1'b0;
        for (int k = 0; k < 10 && !pushed; k++) tick();
        chk("push_accepted", {31'b0, pushed}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        chk("drain_empty", q.size(), 32'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [3:0] op, input logic ill);
        vec_t v;
        v.a = a; v.f3 = f3; v.f7 = f7; v.op = op; v.ill = ill;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUOp = '0; Funct3 = '0; Funct7 = '0; pend = '0; pushed = 1'b0;

        tbl.push_back(mk(2'b10, 3'b000, 7'b0100000, 4'b1001, 1'b0));
        tbl.push_back(mk(2'b10, 3'b000, 7'b0000000, 4'b0011, 1'b0));
        tbl.push_back(mk(2'b10, 3'b101, 7'b0100000, 4'b1010, 1'b0));
        tbl.push_back(mk(2'b10, 3'b101, 7'b0000000, 4'b1011, 1'b0));
        tbl.push_back(mk(2'b10, 3'b001, 7'b0000000, 4'b1100, 1'b0));
        tbl.push_back(mk(2'b10, 3'b011, 7'b0000000, 4'b1111, 1'b1));
        tbl.push_back(mk(2'b10, 3'b111, 7'b0000000, 4'b0000, 1'b0));
        tbl.push_back(mk(2'b10, 3'b110, 7'b0000000, 4'b0001, 1'b0));
        tbl.push_back(mk(2'b10, 3'b100, 7'b0000000, 4'b0010, 1'b0));
        tbl.push_back(mk(2'b10, 3'b010, 7'b0000000, 4'b0111, 1'b0));
        tbl.push_back(mk(2'b01, 3'b000, 7'b0000000, 4'b1000, 1'b0));
        tbl.push_back(mk(2'b01, 3'b001, 7'b0000000, 4'b0100, 1'b0));
        tbl.push_back(mk(2'b01, 3'b100, 7'b0000000, 4'b0101, 1'b0));
        tbl.push_back(mk(2'b01, 3'b101, 7'b0000000, 4'b0110, 1'b0));
        tbl.push_back(mk(2'b01, 3'b110, 7'b0000000, 4'b1111, 1'b1));
        tbl.push_back(mk(2'b01, 3'b010, 7'b0000000, 4'b1111, 1'b1));
        tbl.push_back(mk(2'b00, 3'b101, 7'b0100000, 4'b0011, 1'b0));
        tbl.push_back(mk(2'b11, 3'b000, 7'b0100000, 4'b0011, 1'b0));
        tbl.push_back(mk(2'b11, 3'b101, 7'b0100000, 4'b1010, 1'b0));
        tbl.push_back(mk(2'b11, 3'b010, 7'b0000000, 4'b0111, 1'b0));
        tbl.push_back(mk(2'b11, 3'b011, 7'b0000000, 4'b1111, 1'b1));

        // Power-on reset
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_operation", {28'b0, Operation}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("release_in_ready_high", {31'b0, in_ready}, 32'd1);

        // Pop at empty is ignored
        out_ready = 1'b1;
        tick();
        chk("empty_pop_valid", {31'b0, out_valid}, 32'd0);

        // Directed sweep, one request at a time with latency check
        foreach (tbl[i]) begin
            send(tbl[i]);
            #1 chk("latency_valid", {31'b0, out_valid}, 32'd1);
            tick();
        end
        drain();

        // Back-pressure
        out_ready = 1'b0;
        send(mk(2'b00, 3'b111, 7'b1111111, 4'b0011, 1'b0));
        send(mk(2'b10, 3'b100, 7'b0000000, 4'b0010, 1'b0));
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        set_req(mk(2'b10, 3'b001, 7'b0000000, 4'b1100, 1'b0));
        repeat (3) begin
            tick();
            chk("bp_held", {31'b0, pushed}, 32'd0);
            chk("bp_hold_op", {28'b0, Operation}, 32'h3);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        pushed = 1'b0;
        for (int k = 0; k < 10 && !pushed; k++) tick();
        chk("bp_third_push", {31'b0, pushed}, 32'd1);
        in_valid = 1'b0;
        drain();

        // Simultaneous push/pop streaming
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_req(tbl[$urandom_range(0, tbl.size() - 1)]);
            tick();
            chk("stream_push", {31'b0, pushed}, 32'd1);
            chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        drain();

        // Strict-decode sensitive encodings
`ifdef ALU_STRICT_DECODE_EN
        send(mk(2'b10, 3'b111, 7'b0000001, 4'b1111, 1'b1));
        send(mk(2'b10, 3'b000, 7'b0000001, 4'b1111, 1'b1));
        send(mk(2'b11, 3'b001, 7'b0100000, 4'b1111, 1'b1));
        send(mk(2'b11, 3'b101, 7'b1100000, 4'b1111, 1'b1));
`else
        send(mk(2'b10, 3'b111, 7'b0000001, 4'b0000, 1'b0));
        send(mk(2'b10, 3'b000, 7'b0000001, 4'b0011, 1'b0));
        send(mk(2'b11, 3'b001, 7'b0100000, 4'b1100, 1'b0));
        send(mk(2'b11, 3'b101, 7'b1100000, 4'b1010, 1'b0));
`endif
        drain();

        // Reset mid-stream with two entries buffered
        out_ready = 1'b0;
        send(mk(2'b10, 3'b110, 7'b0000000, 4'b0001, 1'b0));
        send(mk(2'b10, 3'b011, 7'b0000000, 4'b1111, 1'b1));
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_operation", {28'b0, Operation}, 32'd0);
        chk("mid_rst_illegal", {31'b0, illegal}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_release_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("mid_release_high", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        send(mk(2'b11, 3'b100, 7'b0000000, 4'b0010, 1'b0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
